mic_frame_buffer: RTL

MIC_FRAME_BUFFER -- requirements
Module: mic_frame_buffer

---
 rtl/mic_frame_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mic_frame_buffer.sv
// Double-banked multichannel microphone frame buffer. The writer FSM fills one bank while the reader
// owns the other. Define MIC_OVERRUN_CNT_EN to add a saturating 16-bit overrun counter output.
module mic_frame_buffer #(
   parameter int N_CH  = 4,
   parameter int DEPTH = 512,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  sample_valid,
   input  logic [N_CH*WIDTH-1:0] sample_data,
   input  logic [CW-1:0]         rd_ch,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  frame_ready,
   input  logic                  rd_done,
   output logic                  wr_bank,
   output logic                  busy,
   output logic                  overrun,
`ifdef MIC_OVERRUN_CNT_EN
   output logic [15:0]           overrun_cnt,
`endif
   output logic [1:0]            dbg_state
);

   // Debug encoding of dbg_state: 0 = IDLE, 1 = FILL, 2 = HOLD.
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HOLD = 2'd2} state_e;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [CW:0]   NCH_L     = (CW + 1)'(N_CH);

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_addr_q, wr_addr_d;
   logic             wr_bank_q, wr_bank_d;
   logic             frame_ready_q, frame_ready_d;
   logic             overrun_q, overrun_d;
   logic             wr_en;
   logic             ch_ok;
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] mem_q [2][N_CH][DEPTH];

   // Channel selects beyond N_CH read as zero; only needed when CW can encode more than N_CH.
   if ((1 << CW) > N_CH) begin : g_ch_guard
      assign ch_ok = ({1'b0, rd_ch} < NCH_L);
   end else begin : g_ch_full
      assign ch_ok = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      wr_bank_d     = wr_bank_q;
      frame_ready_d = frame_ready_q;
      overrun_d     = 1'b0;
      wr_en         = 1'b0;
      if (rd_done && frame_ready_q) frame_ready_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FILL;
               wr_addr_d = '0;
            end
         end
         FILL: begin
            if (!start) begin
               state_d   = IDLE;
               wr_addr_d = '0;
            end else if (sample_valid) begin
               wr_en = 1'b1;
               if (wr_addr_q == LAST_ADDR) begin
                  wr_addr_d = '0;
                  // A release in the completion cycle frees the reader bank in time to swap.
                  if (!frame_ready_q || rd_done) begin
                     wr_bank_d     = ~wr_bank_q;
                     frame_ready_d = 1'b1;
                  end else begin
                     state_d   = HOLD;
                     overrun_d = 1'b1;
                  end
               end else begin
                  wr_addr_d = wr_addr_q + AW'(1);
               end
            end
         end
         HOLD: begin
            if (rd_done) begin
               wr_bank_d     = ~wr_bank_q;
               frame_ready_d = 1'b1;
               wr_addr_d     = '0;
               state_d       = start ? FILL : IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            wr_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_addr_q     <= '0;
         wr_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         wr_bank_q     <= wr_bank_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         rd_data_q     <= ch_ok ? mem_q[~wr_bank_q][rd_ch][rd_addr] : '0;
      end
   end

   // Sample storage carries no reset; a frame only becomes visible after a full write pass.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         for (int k = 0; k < N_CH; k++) begin
            mem_q[wr_bank_q][k][wr_addr_q] <= sample_data[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MIC_OVERRUN_CNT_EN
   logic [15:0] overrun_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_cnt_q <= '0;
      end else if (overrun_d && (overrun_cnt_q != 16'hFFFF)) begin
         overrun_cnt_q <= overrun_cnt_q + 16'd1;
      end
   end

   assign overrun_cnt = overrun_cnt_q;
`endif

   assign rd_data     = rd_data_q;
   assign frame_ready = frame_ready_q;
   assign wr_bank     = wr_bank_q;
   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign dbg_state   = state_q;

endmodule
